// File: rtl/apu_arbiter.sv
// apu_arbiter: shares one APU request/response port between NREQ requesters.
// Arbitration is round-robin. Only one transaction is outstanding at a time.
// The selection stays locked until the APU grants. The response is then routed
// back to the requester that owns the transaction.
// Optional feature: define APU_ARBITER_TIMEOUT_EN to enable a response watchdog.
//
// state  | meaning
// IDLE   | no transaction; pick the round-robin winner and request the APU
// REQ    | winner latched in owner; waiting for apu_gnt_i
// WAIT   | granted; waiting for apu_rvalid_i (or the watchdog, if enabled)

module apu_arbiter #(
    parameter int NREQ           = 2,
    parameter int NARGS          = 3,   // APU_NARGS_CPU
    parameter int WOP            = 6,   // APU_WOP_CPU
    parameter int NDSFLAGS       = 15,  // APU_NDSFLAGS_CPU
    parameter int NUSFLAGS       = 5,   // APU_NUSFLAGS_CPU
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NREQ-1:0]                     req_i,
    input  logic [NREQ-1:0][NARGS-1:0][31:0]    operands_i,
    input  logic [NREQ-1:0][WOP-1:0]            op_i,
    input  logic [NREQ-1:0][NDSFLAGS-1:0]       flags_i,
    output logic [NREQ-1:0]                     gnt_o,
    output logic [NREQ-1:0]                     rvalid_o,
    output logic [31:0]                         result_o,
    output logic [NUSFLAGS-1:0]                 flags_o,
    output logic                                timeout_o,
    output logic                                apu_req_o,
    output logic [NARGS-1:0][31:0]              apu_operands_o,
    output logic [WOP-1:0]                      apu_op_o,
    output logic [NDSFLAGS-1:0]                 apu_flags_o,
    input  logic                                apu_gnt_i,
    input  logic                                apu_rvalid_i,
    input  logic [31:0]                         apu_result_i,
    input  logic [NUSFLAGS-1:0]                 apu_flags_i
);

    localparam int RRW = $clog2(NREQ);
    localparam int SW  = RRW + 1;
    localparam logic [RRW-1:0] LAST = RRW'(NREQ - 1);

    if (NREQ < 2 || NREQ > 4 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("apu_arbiter: NREQ must be 2..4 and TIMEOUT_CYCLES at least 1");
    end

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

    state_e         state_q;
    logic [RRW-1:0] rr_q;
    logic [RRW-1:0] owner_q;
    logic [RRW-1:0] owner_next;
    logic [RRW-1:0] winner;
    logic [RRW-1:0] sel;
    logic [SW-1:0]  idx;
    logic           found;
    logic           any_req;
    logic           active;
    logic           done;
    logic           timeout_hit;

    assign any_req    = |req_i;
    assign owner_next = (owner_q == LAST) ? '0 : owner_q + RRW'(1);

    // first set request scanning upward from rr, wrapping at NREQ
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = {1'b0, rr_q} + SW'(i);
            if (idx >= SW'(NREQ)) idx = idx - SW'(NREQ);
            if (!found && req_i[idx[RRW-1:0]]) begin
                found  = 1'b1;
                winner = idx[RRW-1:0];
            end
        end
    end

`ifdef APU_ARBITER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt_q;

    assign timeout_hit = (cnt_q == TO_LIMIT);
    assign timeout_o   = (state_q == S_WAIT) && !apu_rvalid_i && timeout_hit;

    // watchdog: cleared on WAIT entry, counts WAIT cycles without a response
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (state_q != S_WAIT) begin
            cnt_q <= '0;
        end else if (!apu_rvalid_i && !timeout_hit) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout_o   = 1'b0;
`endif

    // grant, response routing and request-channel mux; channel is zero when idle
    always_comb begin
        gnt_o    = '0;
        rvalid_o = '0;
        result_o = '0;
        flags_o  = '0;
        active   = 1'b0;
        sel      = owner_q;
        done     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    active        = 1'b1;
                    sel           = winner;
                    gnt_o[winner] = apu_gnt_i;
                end
            end
            S_REQ: begin
                active         = req_i[owner_q];
                gnt_o[owner_q] = apu_gnt_i & req_i[owner_q];
            end
            S_WAIT: begin
                if (apu_rvalid_i) begin
                    rvalid_o[owner_q] = 1'b1;
                    result_o          = apu_result_i;
                    flags_o           = apu_flags_i;
                    done              = 1'b1;
                end else if (timeout_hit) begin
                    rvalid_o[owner_q] = 1'b1;
                    done              = 1'b1;
                end
            end
            default: ;
        endcase
        apu_req_o      = active;
        apu_operands_o = active ? operands_i[sel] : '0;
        apu_op_o       = active ? op_i[sel]       : '0;
        apu_flags_o    = active ? flags_i[sel]    : '0;
    end

    // transaction FSM; rr only advances when a transaction completes
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            rr_q    <= '0;
            owner_q <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (any_req) begin
                        owner_q <= winner;
                        state_q <= apu_gnt_i ? S_WAIT : S_REQ;
                    end
                end
                S_REQ: begin
                    if (!req_i[owner_q]) state_q <= S_IDLE;
                    else if (apu_gnt_i)  state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (done) begin
                        rr_q    <= owner_next;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apu_arbiter.sv
// Testbench for apu_arbiter (NREQ=2). It uses a transaction-level reference
// model: which requester holds the port, whether the APU has accepted the
// request, and how long the bench has waited for the response.
module tb_apu_arbiter;

    localparam int NREQ = 2, NARGS = 3, WOP = 6, NDS = 15, NUS = 5, TOC = 4;
`ifdef APU_ARBITER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic                             clk_i = 1'b0;
    logic                             rst_ni;
    logic [NREQ-1:0]                  req_i;
    logic [NREQ-1:0][NARGS-1:0][31:0] operands_i;
    logic [NREQ-1:0][WOP-1:0]         op_i;
    logic [NREQ-1:0][NDS-1:0]         flags_i;
    logic [NREQ-1:0]                  gnt_o, rvalid_o;
    logic [31:0]                      result_o;
    logic [NUS-1:0]                   flags_o;
    logic                             timeout_o, apu_req_o;
    logic [NARGS-1:0][31:0]           apu_operands_o;
    logic [WOP-1:0]                   apu_op_o;
    logic [NDS-1:0]                   apu_flags_o;
    logic                             apu_gnt_i, apu_rvalid_i;
    logic [31:0]                      apu_result_i;
    logic [NUS-1:0]                   apu_flags_i;

    apu_arbiter #(.NREQ(NREQ), .NARGS(NARGS), .WOP(WOP), .NDSFLAGS(NDS),
                  .NUSFLAGS(NUS), .TIMEOUT_CYCLES(TOC)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .operands_i(operands_i),
        .op_i(op_i), .flags_i(flags_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
        .result_o(result_o), .flags_o(flags_o), .timeout_o(timeout_o),
        .apu_req_o(apu_req_o), .apu_operands_o(apu_operands_o), .apu_op_o(apu_op_o),
        .apu_flags_o(apu_flags_o), .apu_gnt_i(apu_gnt_i), .apu_rvalid_i(apu_rvalid_i),
        .apu_result_i(apu_result_i), .apu_flags_i(apu_flags_i));

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: owner of the port (-1 = free), accepted flag, wait count
    int m_rr, m_pend, m_acc, m_wait;
    bit zero_res = 1'b0;
    bit dummy_prev = 1'b0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_rr = 0; m_pend = -1; m_acc = 0; m_wait = 0; dummy_prev = 1'b0;
    endtask

    function automatic int rr_winner(input logic [1:0] req);
        for (int k = 0; k < NREQ; k++)
            if (req[(m_rr + k) % NREQ]) return (m_rr + k) % NREQ;
        return -1;
    endfunction

    function automatic bit model_wants_apu(input logic [1:0] req);
        if (m_pend < 0) return req != 2'b00;
        if (m_acc == 0) return req[m_pend];
        return 1'b0;
    endfunction

    // one clock: drive inputs, check outputs against the model, advance model
    task automatic cycle(input logic [1:0] req, input logic gnt, input logic rv);
        logic [1:0]  e_gnt, e_rv;
        logic [31:0] e_res;
        logic [4:0]  e_fl;
        logic        e_to, e_req;
        logic [95:0] e_ops;
        logic [5:0]  e_op;
        logic [14:0] e_dfl;
        int w, src;
        req_i = req; apu_gnt_i = gnt; apu_rvalid_i = rv;
        for (int r = 0; r < NREQ; r++) begin
            operands_i[r] = {$urandom, $urandom, $urandom};
            op_i[r]       = 6'($urandom);
            flags_i[r]    = 15'($urandom);
        end
        apu_result_i = zero_res ? 32'd0 : $urandom;
        apu_flags_i  = zero_res ? 5'd0 : 5'($urandom);
        #1;
        e_gnt = '0; e_rv = '0; e_res = '0; e_fl = '0; e_to = 1'b0;
        src = -1; w = rr_winner(req);
        if (m_pend < 0) begin
            if (w >= 0) begin
                src = w;
                if (gnt) e_gnt[w] = 1'b1;
            end
        end else if (m_acc == 0) begin
            if (req[m_pend]) begin
                src = m_pend;
                if (gnt) e_gnt[m_pend] = 1'b1;
            end
        end else begin
            if (rv) begin
                e_rv[m_pend] = 1'b1; e_res = apu_result_i; e_fl = apu_flags_i;
            end else if (TO_EN && m_wait == TOC) begin
                e_rv[m_pend] = 1'b1; e_to = 1'b1;
            end
        end
        e_req = (src >= 0);
        e_ops = e_req ? operands_i[src] : '0;
        e_op  = e_req ? op_i[src] : '0;
        e_dfl = e_req ? flags_i[src] : '0;
        chk("gnt",      128'(gnt_o),          128'(e_gnt));
        chk("rvalid",   128'(rvalid_o),       128'(e_rv));
        chk("result",   128'(result_o),       128'(e_res));
        chk("flags",    128'(flags_o),        128'(e_fl));
        chk("timeout",  128'(timeout_o),      128'(e_to));
        chk("apu_req",  128'(apu_req_o),      128'(e_req));
        chk("apu_ops",  128'(apu_operands_o), 128'(e_ops));
        chk("apu_op",   128'(apu_op_o),       128'(e_op));
        chk("apu_dfl",  128'(apu_flags_o),    128'(e_dfl));
        @(posedge clk_i);
        if (rst_ni) begin
            if (m_pend < 0) begin
                if (w >= 0) begin m_pend = w; m_acc = gnt; m_wait = 0; end
            end else if (m_acc == 0) begin
                if (!req[m_pend]) m_pend = -1;
                else if (gnt) begin m_acc = 1; m_wait = 0; end
            end else begin
                if (rv || (TO_EN && m_wait == TOC)) begin
                    m_rr = (m_pend + 1) % NREQ; m_pend = -1; m_acc = 0;
                end else m_wait++;
            end
        end
        @(negedge clk_i);
    endtask

    // dummy APU: grants whatever is requested, responds one cycle later
    task automatic dummy(input logic [1:0] req);
        logic g;
        g = model_wants_apu(req);
        cycle(req, g, dummy_prev);
        dummy_prev = g;
    endtask

    initial begin
        rst_ni = 1'b0; req_i = '0; operands_i = '0; op_i = '0; flags_i = '0;
        apu_gnt_i = 1'b0; apu_rvalid_i = 1'b0; apu_result_i = '0; apu_flags_i = '0;
        model_reset();
        @(negedge clk_i);
        cycle(2'b00, 1'b0, 1'b0);          // outputs during reset
        rst_ni = 1'b1;
        @(negedge clk_i);

        // single request against the dummy APU, zero result
        zero_res = 1'b1;
        dummy(2'b01);
        dummy(2'b00);
        dummy(2'b00);
        zero_res = 1'b0;

        // contention: grants alternate, two cycles apart
        for (int i = 0; i < 8; i++) dummy(2'b11);
        dummy(2'b00); dummy(2'b00);

        // delayed grant while requester 1 rises
        cycle(2'b01, 1'b0, 1'b0);
        cycle(2'b11, 1'b0, 1'b0);
        cycle(2'b11, 1'b0, 1'b0);
        cycle(2'b11, 1'b1, 1'b0);
        cycle(2'b10, 1'b0, 1'b1);

        // protocol violation: owner drops before grant
        cycle(2'b01, 1'b0, 1'b0);
        cycle(2'b00, 1'b0, 1'b0);
        cycle(2'b00, 1'b0, 1'b0);

        // spurious response in IDLE
        cycle(2'b00, 1'b0, 1'b1);
        cycle(2'b00, 1'b1, 1'b1);

        // reset mid-WAIT after rr has advanced to 1
        cycle(2'b10, 1'b1, 1'b0);
        rst_ni = 1'b0;
        model_reset();
        cycle(2'b00, 1'b0, 1'b1);
        rst_ni = 1'b1;
        cycle(2'b00, 1'b0, 1'b1);
        cycle(2'b11, 1'b1, 1'b0);          // rr back at 0: requester 0 wins
        cycle(2'b10, 1'b0, 1'b1);

        // unresponsive APU: watchdog fires (macro on) or WAIT holds (macro off)
        cycle(2'b01, 1'b1, 1'b0);
        for (int i = 0; i < TOC + 3; i++) cycle(2'b00, 1'b0, 1'b0);
        cycle(2'b00, 1'b0, 1'b1);
        cycle(2'b00, 1'b0, 1'b0);

        // randomized traffic
        for (int i = 0; i < 400; i++)
            cycle(2'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
